// File: rtl/flat_fifo_pkg.sv
// Package: flat_fifo_pkg
// Purpose: width helpers shared by the flat FIFO controller and its pointer sub-module.
//   flat_fifo_addr_w(depth) : pointer / head-index width, $clog2(depth) (at least 1)
//   flat_fifo_cnt_w(depth)  : occupancy width, one more bit than the pointer so DEPTH fits
package flat_fifo_pkg;

   function automatic int unsigned flat_fifo_addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned flat_fifo_cnt_w(input int unsigned depth);
      return flat_fifo_addr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/flat_fifo_ptr.sv
// Module: flat_fifo_ptr
// Purpose: ADDR_W-bit wrapping pointer with increment and synchronous clear.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous reset, active-low (pointer -> 0)
//   clr_i  in   synchronous clear, wins over inc_i
//   inc_i  in   advance pointer by one, wrapping at 2**AddrW
//   ptr_o  out  current pointer value
module flat_fifo_ptr #(
   parameter int unsigned AddrW = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [AddrW-1:0] ptr_o
);

   logic [AddrW-1:0] ptr_q, ptr_d;

   // DEPTH is a power of two, so natural overflow gives the DEPTH-1 -> 0 wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + AddrW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/flat_fifo_ctrl.sv
// Module: flat_fifo_ctrl
// Purpose: circular-buffer FIFO whose storage is exposed as a flattened bus (flat_mem); the
//   head index (rd_addr) selects the head word in a downstream mux. Valid/ready on both sides,
//   occupancy count, full/empty flags and a synchronous flush.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                synchronous clear of pointers and count (storage kept)
//   wr_valid/wr_ready    push handshake, wr_ready = !full
//   wr_data              entry to push
//   rd_valid/rd_ready    pop handshake, rd_valid = !empty
//   flat_mem             entry i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   rd_addr              head index
//   count, full, empty   occupancy 0..DEPTH and its flags
// Optional (macro FLAT_FIFO_ERR_FLAGS_EN):
//   err_clr              clears the sticky error flags (a new set wins)
//   ovf_err              sticky: write attempted while full
//   udf_err              sticky: read attempted while empty
module flat_fifo_ctrl
   import flat_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DATA_WIDTH*DEPTH-1:0]   flat_mem,
   output logic [$clog2(DEPTH)-1:0]      rd_addr,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          full,
`ifdef FLAT_FIFO_ERR_FLAGS_EN
   input  logic                          err_clr,
   output logic                          ovf_err,
   output logic                          udf_err,
`endif
   output logic                          empty
);

   localparam int unsigned ADDR_W = flat_fifo_addr_w(DEPTH);
   localparam int unsigned CNT_W  = flat_fifo_cnt_w(DEPTH);

   logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  push, pop;

   // Flags come straight from the count register, so no input reaches an output.
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign wr_ready = ~full;
   assign rd_valid = ~empty;
   assign push     = wr_valid & ~full;
   assign pop      = rd_valid & rd_ready;

   flat_fifo_ptr #(
      .AddrW (ADDR_W)
   ) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .inc_i (push),
      .ptr_o (wr_ptr)
   );

   flat_fifo_ptr #(
      .AddrW (ADDR_W)
   ) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (flush),
      .inc_i (pop),
      .ptr_o (rd_ptr)
   );

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Flush suppresses the write so storage is left exactly as it was.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (push && !flush) begin
         mem_q[wr_ptr] <= wr_data;
      end
   end

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
      assign flat_mem[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
   end

   assign rd_addr = rd_ptr;
   assign count   = count_q;

`ifdef FLAT_FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= (wr_valid & full)  | (ovf_q & ~err_clr);
         udf_q <= (rd_ready & empty) | (udf_q & ~err_clr);
      end
   end

   assign ovf_err = ovf_q;
   assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_flat_fifo_ctrl.sv
// Testbench for flat_fifo_ctrl (DATA_WIDTH=16, DEPTH=4): a scoreboard queue receives every
// accepted push and is popped whenever a pop is issued; state is checked against a small model.
module tb_flat_fifo_ctrl;

   localparam int unsigned DW = 16;
   localparam int unsigned DP = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic           wr_valid;
   logic           wr_ready;
   logic [DW-1:0]  wr_data;
   logic           rd_valid;
   logic           rd_ready;
   logic [DW*DP-1:0] flat_mem;
   logic [1:0]     rd_addr;
   logic [2:0]     count;
   logic           full;
   logic           empty;
   logic           err_clr;
`ifdef FLAT_FIFO_ERR_FLAGS_EN
   logic           ovf_err;
   logic           udf_err;
`endif

   flat_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .DEPTH      (DP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .flat_mem (flat_mem),
      .rd_addr  (rd_addr),
      .count    (count),
      .full     (full),
`ifdef FLAT_FIFO_ERR_FLAGS_EN
      .err_clr  (err_clr),
      .ovf_err  (ovf_err),
      .udf_err  (udf_err),
`endif
      .empty    (empty)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model
   logic [DW-1:0] sb [$];
   logic [DW-1:0] m_mem [DP];
   logic [1:0]    m_wp, m_rp;
   int            m_cnt;
   logic          m_ovf, m_udf;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_flat();
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < int'(DP); i++) f[i*DW +: DW] = m_mem[i];
      return f;
   endfunction

   task automatic model_reset();
      sb.delete();
      for (int i = 0; i < int'(DP); i++) m_mem[i] = '0;
      m_wp  = '0;
      m_rp  = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, ".count"},    64'(count),    64'(m_cnt));
      check_eq({tag, ".full"},     64'(full),     64'(m_cnt == int'(DP)));
      check_eq({tag, ".empty"},    64'(empty),    64'(m_cnt == 0));
      check_eq({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_cnt != 0));
      check_eq({tag, ".wr_ready"}, 64'(wr_ready), 64'(m_cnt != int'(DP)));
      check_eq({tag, ".rd_addr"},  64'(rd_addr),  64'(m_rp));
      check_eq({tag, ".flat_mem"}, flat_mem,      model_flat());
`ifdef FLAT_FIFO_ERR_FLAGS_EN
      check_eq({tag, ".ovf_err"},  64'(ovf_err),  64'(m_ovf));
      check_eq({tag, ".udf_err"},  64'(udf_err),  64'(m_udf));
`endif
   endtask

   // Drive one cycle of stimulus (called just after a rising edge), then check state.
   task automatic step(input string tag, input logic wv, input logic [DW-1:0] wd,
                       input logic rr, input logic fl, input logic ec);
      logic          do_push, do_pop;
      logic [DW-1:0] exp_head;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      err_clr  = ec;
      do_push  = wv && (m_cnt < int'(DP));
      do_pop   = rr && (m_cnt > 0);
      if (do_pop) begin
         exp_head = sb.pop_front();
         check_eq({tag, ".head"}, 64'(flat_mem[rd_addr*DW +: DW]), 64'(exp_head));
      end
      m_ovf = (wv && (m_cnt == int'(DP))) || (m_ovf && !ec);
      m_udf = (rr && (m_cnt == 0)) || (m_udf && !ec);
      if (fl) begin
         sb.delete();
         m_wp  = '0;
         m_rp  = '0;
         m_cnt = 0;
      end else begin
         if (do_push) begin
            m_mem[m_wp] = wd;
            m_wp        = m_wp + 2'd1;
            sb.push_back(wd);
         end
         if (do_pop) m_rp = m_rp + 2'd1;
         m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      end
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic apply_reset();
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
      flush    = 1'b0;
      err_clr  = 1'b0;
      rst_n    = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_state("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      #2;
      apply_reset();

      // Fill, then an ignored fifth push
      step("fill0", 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
      step("fill1", 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
      step("fill2", 1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
      step("fill3", 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
      check_eq("fill.flat", flat_mem, 64'h4444_3333_2222_1111);
      step("ovf",   1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);

      // Full with simultaneous push and pop: only the pop happens
      step("fullpp", 1'b1, 16'h6666, 1'b1, 1'b0, 1'b0);
      check_eq("fullpp.mem0", 64'(flat_mem[15:0]), 64'h1111);

      // Wrap the write pointer, then drain through the wrap
      step("wrap", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
      check_eq("wrap.mem0", 64'(flat_mem[15:0]), 64'hAAAA);
      for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      check_eq("drain.rd_addr", 64'(rd_addr), 64'd1);
      step("udf",   1'b0, '0, 1'b1, 1'b0, 1'b0);
      step("idle",  1'b0, '0, 1'b0, 1'b0, 1'b0);
      step("errclr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Flush overrides a simultaneous push and pop
      step("pre0", 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      step("pre1", 1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b0);
      step("flush", 1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
      check_eq("flush.count", 64'(count), 64'd0);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0));
      end

      // Asynchronous reset in the middle of a push
      step("pre_rst", 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      wr_valid = 1'b1;
      wr_data  = 16'h5678;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async.count", 64'(count),    64'd0);
      check_eq("async.flat",  flat_mem,      64'd0);
      check_eq("async.empty", 64'(empty),    64'd1);
      check_eq("async.addr",  64'(rd_addr),  64'd0);
      @(posedge clk);
      #1;
      check_state("in_rst");
      rst_n    = 1'b1;
      wr_valid = 1'b0;
      step("post_rst", 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0);
      step("post_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
